// File: rtl/gb_mem_pkg.sv
// Shared types and address map for the Game Boy memory mapper.
// Region decode is purely combinational; nothing in this package holds state.
package gb_mem_pkg;

  typedef enum logic [2:0] {
    RGN_ROM0,
    RGN_ROMX,
    RGN_CRAM,
    RGN_WRAM,
    RGN_ECHO,
    RGN_UNMAPPED
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CART,
    ST_WRAM,
    ST_ACK
  } state_e;

  localparam int MBC_NONE = 0;
  localparam int MBC_1    = 1;
  localparam int MBC_5    = 5;

  localparam logic [15:0] ROMX_BASE = 16'h4000;
  localparam logic [15:0] ROM_LAST  = 16'h7FFF;
  localparam logic [15:0] CRAM_BASE = 16'hA000;
  localparam logic [15:0] CRAM_LAST = 16'hBFFF;
  localparam logic [15:0] WRAM_BASE = 16'hC000;
  localparam logic [15:0] WRAM_LAST = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE = 16'hE000;
  localparam logic [15:0] ECHO_LAST = 16'hFDFF;

  function automatic region_e decode_region(input logic [15:0] a);
    region_e r;
    if (a < ROMX_BASE)                         r = RGN_ROM0;
    else if (a <= ROM_LAST)                    r = RGN_ROMX;
    else if (a >= CRAM_BASE && a <= CRAM_LAST) r = RGN_CRAM;
    else if (a >= WRAM_BASE && a <= WRAM_LAST) r = RGN_WRAM;
    else if (a >= ECHO_BASE && a <= ECHO_LAST) r = RGN_ECHO;
    else                                       r = RGN_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/gb_mem_map_if.sv
// CPU, cartridge and work-RAM signal bundle for gb_mem_map.
// slave is the mapper side; master is the CPU/cartridge/RAM environment.
interface gb_mem_map_if #(
  parameter int ROM_BANK_BITS = 9
);
  logic [15:0]               A;
  logic                      RD;
  logic                      WR;
  logic [7:0]                D_out;
  logic [7:0]                D_in;
  logic                      READY;
  logic [ROM_BANK_BITS+13:0] CART_ADDR;
  logic [7:0]                CART_DATA_in;
  logic [7:0]                CART_DATA_out;
  logic                      CART_RD;
  logic                      CART_WR;
  logic                      CART_RAM_CS;
  logic [12:0]               WRAM_A;
  logic [7:0]                WRAM_D_in;
  logic [7:0]                WRAM_D_out;
  logic                      WRAM_WE;

  modport slave (
    input  A, RD, WR, D_out, CART_DATA_in, WRAM_D_in,
    output D_in, READY, CART_ADDR, CART_DATA_out, CART_RD, CART_WR,
           CART_RAM_CS, WRAM_A, WRAM_D_out, WRAM_WE
  );

  modport master (
    output A, RD, WR, D_out, CART_DATA_in, WRAM_D_in,
    input  D_in, READY, CART_ADDR, CART_DATA_out, CART_RD, CART_WR,
           CART_RAM_CS, WRAM_A, WRAM_D_out, WRAM_WE
  );
endinterface

// File: rtl/gb_mbc_regs.sv
// Bank-controller register file and bank computation (none / MBC1 / MBC5).
// Registers update on the cycle a ROM-area write is sampled; bank outputs are combinational.
module gb_mbc_regs #(
  parameter int ROM_BANK_BITS = 9,
  parameter int RAM_BANK_BITS = 4,
  parameter int MBC_MODE      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [15:0]              addr_i,
  input  logic [7:0]               wdata_i,
  output logic [ROM_BANK_BITS-1:0] rom0_bank_o,
  output logic [ROM_BANK_BITS-1:0] romx_bank_o,
  output logic [RAM_BANK_BITS-1:0] ram_bank_o,
  output logic                     ram_en_o
);
  import gb_mem_pkg::*;

  // Each controller flavour only looks at part of the bus.
  logic unused_inputs;
  assign unused_inputs = ^{clk_i, rst_i, we_i, addr_i, wdata_i};

  generate
    if (MBC_MODE == MBC_1) begin : g_mbc1
      logic       ram_en_q;
      logic       mode_q;
      logic [1:0] bank2_q;
      logic [4:0] rom_lo_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ram_en_q <= 1'b0;
          mode_q   <= 1'b0;
          bank2_q  <= 2'd0;
          rom_lo_q <= 5'd1;
        end else if (we_i) begin
          case (addr_i[14:13])
            2'd0:    ram_en_q <= (wdata_i[3:0] == 4'hA);
            2'd1:    rom_lo_q <= (wdata_i[4:0] == 5'd0) ? 5'd1 : wdata_i[4:0];
            2'd2:    bank2_q  <= wdata_i[1:0];
            default: mode_q   <= wdata_i[0];
          endcase
        end
      end

      assign romx_bank_o = ROM_BANK_BITS'({bank2_q, rom_lo_q});
      assign rom0_bank_o = mode_q ? ROM_BANK_BITS'({bank2_q, 5'b00000}) : '0;
      assign ram_bank_o  = mode_q ? RAM_BANK_BITS'(bank2_q) : '0;
      assign ram_en_o    = ram_en_q;
    end else if (MBC_MODE == MBC_5) begin : g_mbc5
      logic       ram_en_q;
      logic [8:0] rom_q;
      logic [3:0] ram_bank_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ram_en_q   <= 1'b0;
          rom_q      <= 9'd1;
          ram_bank_q <= 4'd0;
        end else if (we_i) begin
          case (addr_i[14:13])
            2'd0: ram_en_q <= (wdata_i[3:0] == 4'hA);
            2'd1: begin
              if (addr_i[12]) rom_q[8]   <= wdata_i[0];
              else            rom_q[7:0] <= wdata_i;
            end
            2'd2:    ram_bank_q <= wdata_i[3:0];
            default: ;
          endcase
        end
      end

      assign romx_bank_o = ROM_BANK_BITS'(rom_q);
      assign rom0_bank_o = '0;
      assign ram_bank_o  = RAM_BANK_BITS'(ram_bank_q);
      assign ram_en_o    = ram_en_q;
    end else begin : g_fixed
      assign romx_bank_o = ROM_BANK_BITS'(1'b1);
      assign rom0_bank_o = '0;
      assign ram_bank_o  = '0;
      assign ram_en_o    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/gb_mem_map.sv
// CPU address decode and access sequencer: ROM/CRAM via cartridge, WRAM/ECHO via sync RAM.
// READY pulses 1 cycle after sampling (regs/dropped), 2 for WRAM, CART_WAIT+1 for cartridge.
module gb_mem_map #(
  parameter int ROM_BANK_BITS = 9,
  parameter int RAM_BANK_BITS = 4,
  parameter int MBC_MODE      = 1,
  parameter int CART_WAIT     = 2
) (
  input  logic         clk,
  input  logic         rst,
  gb_mem_map_if.slave  bus
);
  import gb_mem_pkg::*;

  localparam int          AW       = ROM_BANK_BITS + 14;
  localparam logic [3:0]  CNT_LAST = 4'(CART_WAIT - 1);

  logic [ROM_BANK_BITS-1:0] rom0_bank, romx_bank;
  logic [RAM_BANK_BITS-1:0] ram_bank;
  logic                     ram_en;
  region_e                  region;
  logic                     req, mbc_we;
  logic [AW-1:0]            cart_addr;

  state_e     state_q, state_d;
  logic       wr_q, wr_d;
  logic       cram_q, cram_d;
  logic       wram_rd_q, wram_rd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;

  logic       cart_rd, cart_wr, cart_cs, wram_we, ready;
  logic [7:0] cart_dout, wram_dout, d_in;

  assign region = decode_region(bus.A);
  assign req    = bus.RD | bus.WR;
  assign mbc_we = (state_q == ST_IDLE) && bus.WR &&
                  (region == RGN_ROM0 || region == RGN_ROMX);

  gb_mbc_regs #(
    .ROM_BANK_BITS (ROM_BANK_BITS),
    .RAM_BANK_BITS (RAM_BANK_BITS),
    .MBC_MODE      (MBC_MODE)
  ) u_mbc (
    .clk_i       (clk),
    .rst_i       (rst),
    .we_i        (mbc_we),
    .addr_i      (bus.A),
    .wdata_i     (bus.D_out),
    .rom0_bank_o (rom0_bank),
    .romx_bank_o (romx_bank),
    .ram_bank_o  (ram_bank),
    .ram_en_o    (ram_en)
  );

  always_comb begin
    cart_addr = '0;
    case (region)
      RGN_CRAM: cart_addr[RAM_BANK_BITS+12:0] = {ram_bank, bus.A[12:0]};
      RGN_ROM0: cart_addr = {rom0_bank, bus.A[13:0]};
      default:  cart_addr = {romx_bank, bus.A[13:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_q      <= 1'b0;
      cram_q    <= 1'b0;
      wram_rd_q <= 1'b0;
      cnt_q     <= 4'd0;
      rdata_q   <= 8'hFF;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      cram_q    <= cram_d;
      wram_rd_q <= wram_rd_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    cram_d    = cram_q;
    wram_rd_d = wram_rd_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    cart_rd   = 1'b0;
    cart_wr   = 1'b0;
    cart_cs   = 1'b0;
    cart_dout = 8'h00;
    wram_we   = 1'b0;
    wram_dout = 8'h00;
    ready     = 1'b0;
    d_in      = 8'hFF;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // WR wins when both strobes are high.
          wr_d      = bus.WR;
          cram_d    = (region == RGN_CRAM);
          wram_rd_d = 1'b0;
          cnt_d     = 4'd0;
          rdata_d   = 8'hFF;
          case (region)
            RGN_ROM0, RGN_ROMX: state_d = bus.WR ? ST_ACK : ST_CART;
            RGN_CRAM:           state_d = ram_en ? ST_CART : ST_ACK;
            RGN_WRAM, RGN_ECHO: begin
              state_d   = ST_WRAM;
              wram_rd_d = ~bus.WR;
            end
            default:            state_d = ST_ACK;
          endcase
        end
      end
      ST_CART: begin
        cart_rd   = ~wr_q;
        cart_wr   = wr_q;
        cart_cs   = cram_q;
        cart_dout = wr_q ? bus.D_out : 8'h00;
        if (cnt_q == CNT_LAST) begin
          if (!wr_q) rdata_d = bus.CART_DATA_in;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WRAM: begin
        wram_we   = wr_q;
        wram_dout = wr_q ? bus.D_out : 8'h00;
        state_d   = ST_ACK;
      end
      default: begin
        // Sync RAM data lands in this cycle, so WRAM reads bypass rdata_q.
        ready   = 1'b1;
        d_in    = wram_rd_q ? bus.WRAM_D_in : rdata_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.CART_ADDR     = cart_addr;
  assign bus.CART_RD       = cart_rd;
  assign bus.CART_WR       = cart_wr;
  assign bus.CART_RAM_CS   = cart_cs;
  assign bus.CART_DATA_out = cart_dout;
  assign bus.WRAM_A        = bus.A[12:0];
  assign bus.WRAM_D_out    = wram_dout;
  assign bus.WRAM_WE       = wram_we;
  assign bus.READY         = ready;
  assign bus.D_in          = d_in;

endmodule

// File: tb/tb_gb_mem_map.sv
// Scoreboard bench: an MBC1 and an MBC5 instance share one stimulus path selected by sel;
// expectations are queued at issue and checked by a monitor whenever READY pulses.
module tb_gb_mem_map;

  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [15:0] a;
  logic        rd, wr;
  logic [7:0]  dout;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gb_mem_map_if bus1 ();
  gb_mem_map_if bus5 ();

  gb_mem_map #(.ROM_BANK_BITS(9), .RAM_BANK_BITS(4), .MBC_MODE(1), .CART_WAIT(CW))
    u_mbc1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  gb_mem_map #(.ROM_BANK_BITS(9), .RAM_BANK_BITS(4), .MBC_MODE(5), .CART_WAIT(CW))
    u_mbc5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  assign bus1.A = a;  assign bus1.D_out = dout;
  assign bus5.A = a;  assign bus5.D_out = dout;
  assign bus1.RD = rd & ~sel;  assign bus1.WR = wr & ~sel;
  assign bus5.RD = rd & sel;   assign bus5.WR = wr & sel;

  // Cartridge model: read data is a fixed function of the presented address.
  assign bus1.CART_DATA_in = bus1.CART_ADDR[7:0] ^ 8'h3C;
  assign bus5.CART_DATA_in = bus5.CART_ADDR[7:0] ^ 8'h3C;

  logic        m_ready, m_rd, m_wr, m_cs, m_we;
  logic [7:0]  m_din, m_cdout, m_wdo;
  logic [22:0] m_addr;
  logic [12:0] m_wa;
  assign m_ready = sel ? bus5.READY         : bus1.READY;
  assign m_rd    = sel ? bus5.CART_RD       : bus1.CART_RD;
  assign m_wr    = sel ? bus5.CART_WR       : bus1.CART_WR;
  assign m_cs    = sel ? bus5.CART_RAM_CS   : bus1.CART_RAM_CS;
  assign m_we    = sel ? bus5.WRAM_WE       : bus1.WRAM_WE;
  assign m_din   = sel ? bus5.D_in          : bus1.D_in;
  assign m_cdout = sel ? bus5.CART_DATA_out : bus1.CART_DATA_out;
  assign m_wdo   = sel ? bus5.WRAM_D_out    : bus1.WRAM_D_out;
  assign m_addr  = sel ? bus5.CART_ADDR     : bus1.CART_ADDR;
  assign m_wa    = sel ? bus5.WRAM_A        : bus1.WRAM_A;

  logic [7:0] wmem [8192];
  logic [7:0] wram_q;
  always @(posedge clk) begin
    if (m_we) wmem[m_wa] <= m_wdo;
    wram_q <= wmem[m_wa];
  end
  assign bus1.WRAM_D_in = wram_q;
  assign bus5.WRAM_D_in = wram_q;

  typedef struct {
    logic [7:0]  d;
    logic [1:0]  kind;   // 0 no cart strobe, 1 CART_RD, 2 CART_WR
    logic [22:0] addr;
    logic        cs;
    logic [7:0]  cdout;
    logic        we;
    logic        wchk;
    logic [12:0] wa;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [1:0] kind,
                              input logic [22:0] addr, input logic cs, input logic [7:0] cdout,
                              input logic we, input logic wchk, input logic [12:0] wa,
                              input int lat);
    exp_t e;
    e.d = d; e.kind = kind; e.addr = addr; e.cs = cs; e.cdout = cdout;
    e.we = we; e.wchk = wchk; e.wa = wa; e.lat = lat; e.issue = 0;
    return e;
  endfunction

  task automatic acc(input logic [15:0] addr, input logic r, input logic w,
                     input logic [7:0] wd, input exp_t e);
    int n;
    @(posedge clk); #1;
    e.issue = cyc;
    q.push_back(e);
    a = addr; rd = r; wr = w; dout = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ready && n < 40);
    if (!m_ready) chk("ready_timeout", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic dropped(input logic [15:0] addr, input logic r, input logic w, input logic [7:0] wd);
    acc(addr, r, w, wd, mk(8'hFF, 2'd0, 23'd0, 1'b0, 8'h00, 1'b0, 1'b0, 13'd0, 1));
  endtask

  task automatic cart_rd(input logic [15:0] addr, input logic [22:0] ca, input logic cs, input logic [7:0] d);
    acc(addr, 1'b1, 1'b0, 8'h00, mk(d, 2'd1, ca, cs, 8'h00, 1'b0, 1'b0, 13'd0, CW + 1));
  endtask

  // Monitor: accumulate strobe activity per access, compare on READY.
  logic        saw_rd, saw_wr, saw_we, last_cs;
  logic [22:0] last_addr;
  logic [7:0]  last_dout;
  int          n_strobe;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      saw_rd = 0; saw_wr = 0; saw_we = 0; last_cs = 0; last_addr = '0; last_dout = '0; n_strobe = 0;
    end else begin
      if (m_rd || m_wr) begin
        n_strobe++;
        if (m_rd) saw_rd = 1'b1;
        if (m_wr) saw_wr = 1'b1;
        last_addr = m_addr; last_cs = m_cs; last_dout = m_cdout;
      end
      if (m_we) saw_we = 1'b1;
      if (m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_ready", 32'(m_ready), 32'd0);
        end else begin
          e = q.pop_front();
          chk("d_in", 32'(m_din), 32'(e.d));
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("strobe_kind", 32'({saw_wr, saw_rd}), 32'(e.kind));
          chk("wram_we", 32'(saw_we), 32'(e.we));
          if (e.kind != 2'd0) begin
            chk("cart_addr", 32'(last_addr), 32'(e.addr));
            chk("cart_ram_cs", 32'(last_cs), 32'(e.cs));
            chk("strobe_cycles", 32'(n_strobe), 32'(CW));
            if (e.kind == 2'd2) chk("cart_data_out", 32'(last_dout), 32'(e.cdout));
          end
          if (e.wchk) chk("wram_a", 32'(m_wa), 32'(e.wa));
        end
        saw_rd = 0; saw_wr = 0; saw_we = 0; last_cs = 0; n_strobe = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; sel = 1'b0; a = '0; rd = 1'b0; wr = 1'b0; dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(m_ready), 32'd0);
    chk("rst_d_in", 32'(m_din), 32'hFF);
    chk("rst_cart_rd", 32'(m_rd), 32'd0);
    chk("rst_cart_wr", 32'(m_wr), 32'd0);
    chk("rst_wram_we", 32'(m_we), 32'd0);
    chk("rst_cart_dout", 32'(m_cdout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // MBC1
    dropped(16'h2000, 1'b0, 1'b1, 8'h00);
    cart_rd(16'h4000, 23'h004000, 1'b0, 8'h3C);
    dropped(16'h4000, 1'b0, 1'b1, 8'h02);
    dropped(16'h6000, 1'b0, 1'b1, 8'h01);
    cart_rd(16'h0123, 23'h100123, 1'b0, 8'h1F);
    cart_rd(16'h4000, 23'h104000, 1'b0, 8'h3C);
    dropped(16'hA000, 1'b0, 1'b1, 8'h77);
    dropped(16'h0000, 1'b0, 1'b1, 8'h0A);
    acc(16'hA010, 1'b0, 1'b1, 8'h77, mk(8'hFF, 2'd2, 23'h004010, 1'b1, 8'h77, 1'b0, 1'b0, 13'd0, CW + 1));
    acc(16'hE005, 1'b0, 1'b1, 8'h5A, mk(8'hFF, 2'd0, 23'd0, 1'b0, 8'h00, 1'b1, 1'b1, 13'h0005, 2));
    acc(16'hC005, 1'b1, 1'b0, 8'h00, mk(8'h5A, 2'd0, 23'd0, 1'b0, 8'h00, 1'b0, 1'b1, 13'h0005, 2));
    dropped(16'hFF80, 1'b1, 1'b1, 8'h99);

    // MBC5
    sel = 1'b1;
    dropped(16'hB000, 1'b1, 1'b0, 8'h00);
    dropped(16'h0000, 1'b0, 1'b1, 8'h0A);
    dropped(16'h4000, 1'b0, 1'b1, 8'h03);
    cart_rd(16'hB000, 23'h007000, 1'b1, 8'h3C);
    dropped(16'h2000, 1'b0, 1'b1, 8'h00);
    cart_rd(16'h4000, 23'h000000, 1'b0, 8'h3C);
    dropped(16'h2000, 1'b0, 1'b1, 8'hFF);
    dropped(16'h3000, 1'b0, 1'b1, 8'h01);
    cart_rd(16'h7FFF, 23'h7FFFFF, 1'b0, 8'hC3);

    // Reset in the middle of a cartridge read
    @(posedge clk); #1 a = 16'h4000; rd = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_cart", 32'(m_rd), 32'd1);
    rst = 1'b1; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", 32'(m_ready), 32'd0);
    chk("abort_cart_rd", 32'(m_rd), 32'd0);
    chk("abort_cart_wr", 32'(m_wr), 32'd0);
    chk("abort_wram_we", 32'(m_we), 32'd0);
    chk("abort_d_in", 32'(m_din), 32'hFF);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_abort_ready", 32'(m_ready), 32'd0);
    end

    // Bank registers are back at their reset values
    cart_rd(16'h4000, 23'h004000, 1'b0, 8'h3C);
    sel = 1'b0;
    cart_rd(16'h0123, 23'h000123, 1'b0, 8'h1F);
    cart_rd(16'h4000, 23'h004000, 1'b0, 8'h3C);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("pending_expectations", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
